int_rs: RTL and testbench
=========================

INT_RS -- requirements
Module: int_rs

Interface
REQ-001 Parameter: DEPTH, default 4, number of reservation-station entries (power of two, 2..8).
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 rename_exers_write  in  1  allocate request from dispatch.
REQ-006 rename_op  in  5  ALU operation code.
REQ-007 rename_robid  in  7  ROB id of the instruction.
REQ-008 rename_rd  in  6  destination; bit 5 set means no writeback register.
REQ-009 rename_op1ready / rename_op2ready  in  1 each  operand holds a value (1) or a tag in bits [6:0] (0).
REQ-010 rename_op1 / rename_op2  in  32 each  operand value or tag.
REQ-011 exers_stall  out  1  station full; dispatch holds its request.
REQ-012 wb_valid  in  1  result broadcast valid.
REQ-013 wb_robid  in  7  tag of the broadcast result.
REQ-014 wb_result  in  32  broadcast result value.
REQ-015 exers_issue_valid  out  1  issue slot holds a ready instruction.
REQ-016 exers_issue_op / _robid / _rd / _op1 / _op2  out  5/7/6/32/32  issued instruction fields.
REQ-017 alu_stall  in  1  ALU cannot accept issue this cycle.
REQ-018 rob_flush  in  1  discard all in-flight entries.

Function
REQ-019 Entries form a collapsing age-ordered queue: entry 0 is the oldest, and valid entries are contiguous from 0.
REQ-020 exers_stall = (occupancy == DEPTH), driven from registered state only, with no dependence on same-cycle issue.
REQ-021 Allocation: when rename_exers_write & ~exers_stall & ~rob_flush, the instruction is written at the first free slot after collapse at the edge.
REQ-022 Allocate bypass: a not-ready operand whose tag equals wb_robid while wb_valid is high is stored as ready with wb_result.
REQ-023 Wakeup: every valid entry operand that is not ready and has a matching wb_robid captures wb_result and is marked ready at the edge; both operands may wake in the same cycle.
REQ-024 Ready entry: valid & op1ready & op2ready.
REQ-025 Issue select: exers_issue_* presents the lowest-index ready entry, combinationally from registered state.
REQ-026 exers_issue_valid = 0 when no entry is ready; the data outputs are don't-care in that case.
REQ-027 Handshake: issue fires when exers_issue_valid & ~alu_stall, and the issued entry is removed at that edge; younger entries shift down by one.
REQ-028 An entry woken in cycle N is eligible for issue in cycle N+1 at the earliest, and an entry allocated in cycle N is also eligible in N+1 at the earliest.
REQ-029 Allocation and issue in the same cycle are both honored, and the new entry lands at index (occupancy-1).
REQ-030 Full and issuing in the same cycle: exers_stall is still 1 and no allocation occurs.
REQ-031 rob_flush: all entries are invalidated at the edge, and any allocate, wakeup, or issue removal in that cycle is ignored.
REQ-032 The issued rd and robid are passed through unmodified, including rd[5].

Reset
REQ-033 rst clears every entry valid bit asynchronously, so that exers_stall = 0 and exers_issue_valid = 0 while rst is high and after it deasserts.
REQ-034 Entry payload registers need no reset.
REQ-035 Reset asserted mid-operation discards all entries with no issue.

Structure
REQ-036 The shared package holds: ROBID_W=7, RSOP_W=5, RD_W=6, XLEN=32, and the entry struct (valid, op, robid, rd, op1ready, op1, op2ready, op2).
REQ-037 Sub-module: int_rs_operand, which holds one operand register with tag-match wakeup; it is instantiated twice per entry.

Verification
REQ-038 Fill scenario: allocate 4 not-ready entries with robids 1..4 -> exers_stall=1 after the 4th edge, and a 5th write is held until an issue.
REQ-039 Wakeup and age scenario: entries A(robid 5, op1 tag 20) and B(robid 6, op1 tag 21); wb 21=0x55 then wb 20=0xAA -> B issues first with op1=0x55, then A with op1=0xAA.
REQ-040 Allocate bypass scenario: write op1ready=0 with tag 9 in the same cycle as wb_valid, wb_robid=9, wb_result=0x1234 -> the entry issues next cycle with op1=0x1234.
REQ-041 Backpressure scenario: a ready entry with alu_stall=1 for 3 cycles -> exers_issue_valid stays 1 with stable fields, then the entry is removed on the first cycle alu_stall=0.
REQ-042 Flush scenario: 3 entries valid, rob_flush and rename_exers_write asserted together -> occupancy 0 next cycle and exers_issue_valid=0.
REQ-043 Reset scenario: rst asserted mid-cycle while full -> exers_stall drops immediately without waiting for a clock edge.

Source files
------------

// File: rtl/int_rs_pkg.sv
// Shared widths and the reservation-station entry layout for the integer
// issue queue.
package int_rs_pkg;

    localparam int ROBID_W = 7;
    localparam int RSOP_W  = 5;
    localparam int RD_W    = 6;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic              valid;
        logic [RSOP_W-1:0] op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]   rd;
        logic              op1ready;
        logic [XLEN-1:0]   op1;
        logic              op2ready;
        logic [XLEN-1:0]   op2;
    } rs_entry_t;

endpackage

// File: rtl/int_rs_if.sv
// Dispatch, writeback, issue and flush signals of the integer reservation
// station, bundled with a driver-side and a station-side view.
interface int_rs_if;
    import int_rs_pkg::*;

    logic               rename_exers_write;
    logic [RSOP_W-1:0]  rename_op;
    logic [ROBID_W-1:0] rename_robid;
    logic [RD_W-1:0]    rename_rd;
    logic               rename_op1ready;
    logic               rename_op2ready;
    logic [XLEN-1:0]    rename_op1;
    logic [XLEN-1:0]    rename_op2;
    logic               exers_stall;

    logic               wb_valid;
    logic [ROBID_W-1:0] wb_robid;
    logic [XLEN-1:0]    wb_result;

    logic               exers_issue_valid;
    logic [RSOP_W-1:0]  exers_issue_op;
    logic [ROBID_W-1:0] exers_issue_robid;
    logic [RD_W-1:0]    exers_issue_rd;
    logic [XLEN-1:0]    exers_issue_op1;
    logic [XLEN-1:0]    exers_issue_op2;
    logic               alu_stall;

    logic               rob_flush;

    modport master (
        output rename_exers_write, rename_op, rename_robid, rename_rd,
               rename_op1ready, rename_op2ready, rename_op1, rename_op2,
               wb_valid, wb_robid, wb_result, alu_stall, rob_flush,
        input  exers_stall, exers_issue_valid, exers_issue_op,
               exers_issue_robid, exers_issue_rd, exers_issue_op1,
               exers_issue_op2
    );

    modport slave (
        input  rename_exers_write, rename_op, rename_robid, rename_rd,
               rename_op1ready, rename_op2ready, rename_op1, rename_op2,
               wb_valid, wb_robid, wb_result, alu_stall, rob_flush,
        output exers_stall, exers_issue_valid, exers_issue_op,
               exers_issue_robid, exers_issue_rd, exers_issue_op1,
               exers_issue_op2
    );

endinterface

// File: rtl/int_rs_operand.sv
// One source-operand register. The incoming value (held, shifted or freshly
// allocated) is woken by a matching writeback broadcast before it is stored.
module int_rs_operand
    import int_rs_pkg::*;
(
    input  logic               clk,
    input  logic               src_ready,
    input  logic [XLEN-1:0]    src_value,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [XLEN-1:0]    wb_result,
    output logic               ready,
    output logic [XLEN-1:0]    value
);

    logic wake;

    // A not-ready operand carries its producer tag in the low bits.
    assign wake = ~src_ready & wb_valid & (src_value[ROBID_W-1:0] == wb_robid);

    always_ff @(posedge clk) begin
        ready <= src_ready | wake;
        value <= wake ? wb_result : src_value;
    end

endmodule

// File: rtl/int_rs.sv
// Integer reservation station: a collapsing, age-ordered queue that wakes
// operands on writeback and issues the oldest ready entry to the ALU.
module int_rs
    import int_rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    int_rs_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]   valid;
    logic [RSOP_W-1:0]  op_q    [DEPTH];
    logic [ROBID_W-1:0] robid_q [DEPTH];
    logic [RD_W-1:0]    rd_q    [DEPTH];
    logic [DEPTH-1:0]   op1_ready;
    logic [DEPTH-1:0]   op2_ready;
    logic [XLEN-1:0]    op1_val [DEPTH];
    logic [XLEN-1:0]    op2_val [DEPTH];

    rs_entry_t          cur [DEPTH];
    rs_entry_t          nxt [DEPTH];
    rs_entry_t          alloc_entry;

    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   occ_after_issue;
    logic [IDX_W-1:0]   sel;
    logic               issue_valid;
    logic               fire;
    logic               stall;
    logic               alloc;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cur[i] = '{valid: valid[i], op: op_q[i], robid: robid_q[i],
                       rd: rd_q[i], op1ready: op1_ready[i], op1: op1_val[i],
                       op2ready: op2_ready[i], op2: op2_val[i]};
        end
    end

    always_comb begin
        alloc_entry = '{valid: 1'b1, op: bus.rename_op, robid: bus.rename_robid,
                        rd: bus.rename_rd, op1ready: bus.rename_op1ready,
                        op1: bus.rename_op1, op2ready: bus.rename_op2ready,
                        op2: bus.rename_op2};
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CNT_W'(valid[i]);
        end
    end

    // Scan from the top so the lowest-index (oldest) ready entry wins.
    always_comb begin
        issue_valid = 1'b0;
        sel         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cur[i].valid && cur[i].op1ready && cur[i].op2ready) begin
                issue_valid = 1'b1;
                sel         = IDX_W'(i);
            end
        end
    end

    assign stall           = (occ == CNT_W'(DEPTH));
    assign fire            = issue_valid & ~bus.alu_stall;
    assign alloc           = bus.rename_exers_write & ~stall & ~bus.rob_flush;
    assign occ_after_issue = occ - CNT_W'(fire);

    // Next image of every slot: collapse over the issued entry, then drop the
    // new instruction into the first free slot of the collapsed queue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = cur[i];
            if (fire && i >= int'(sel)) begin
                nxt[i] = cur[(i < DEPTH - 1) ? i + 1 : i];
                if (i == DEPTH - 1) begin
                    nxt[i].valid = 1'b0;
                end
            end
            if (alloc && occ_after_issue == CNT_W'(i)) begin
                nxt[i] = alloc_entry;
            end
            if (bus.rob_flush) begin
                nxt[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i] <= nxt[i].valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]    <= nxt[i].op;
            robid_q[i] <= nxt[i].robid;
            rd_q[i]    <= nxt[i].rd;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        int_rs_operand u_op1 (
            .clk       (clk),
            .src_ready (nxt[g].op1ready),
            .src_value (nxt[g].op1),
            .wb_valid  (bus.wb_valid),
            .wb_robid  (bus.wb_robid),
            .wb_result (bus.wb_result),
            .ready     (op1_ready[g]),
            .value     (op1_val[g])
        );

        int_rs_operand u_op2 (
            .clk       (clk),
            .src_ready (nxt[g].op2ready),
            .src_value (nxt[g].op2),
            .wb_valid  (bus.wb_valid),
            .wb_robid  (bus.wb_robid),
            .wb_result (bus.wb_result),
            .ready     (op2_ready[g]),
            .value     (op2_val[g])
        );
    end

    assign bus.exers_stall       = stall;
    assign bus.exers_issue_valid = issue_valid;
    assign bus.exers_issue_op    = cur[sel].op;
    assign bus.exers_issue_robid = cur[sel].robid;
    assign bus.exers_issue_rd    = cur[sel].rd;
    assign bus.exers_issue_op1   = cur[sel].op1;
    assign bus.exers_issue_op2   = cur[sel].op2;

endmodule

// File: tb/tb_int_rs.sv
// Scoreboard bench for int_rs: directed scenarios push the issue order they
// expect, and a negedge monitor checks every instruction the station issues.
module tb_int_rs;
    import int_rs_pkg::*;

    typedef struct packed {
        logic [RSOP_W-1:0]  op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
    } rec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    rec_t exp_q [$];

    int_rs_if bus ();

    int_rs #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [81:0] actual,
                                input logic [81:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic rec_t mk(input int robid, input int op, input int rd,
                                input logic [31:0] op1, input logic [31:0] op2);
        rec_t r;
        r.op    = RSOP_W'(op);
        r.robid = ROBID_W'(robid);
        r.rd    = RD_W'(rd);
        r.op1   = op1;
        r.op2   = op2;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int robid, input int op, input int rd,
                                  input logic r1, input logic [31:0] v1,
                                  input logic r2, input logic [31:0] v2);
        bus.rename_exers_write = 1'b1;
        bus.rename_robid       = ROBID_W'(robid);
        bus.rename_op          = RSOP_W'(op);
        bus.rename_rd          = RD_W'(rd);
        bus.rename_op1ready    = r1;
        bus.rename_op1         = v1;
        bus.rename_op2ready    = r2;
        bus.rename_op2         = v2;
    endtask

    task automatic broadcast(input int tag, input logic [31:0] result);
        bus.wb_valid  = 1'b1;
        bus.wb_robid  = ROBID_W'(tag);
        bus.wb_result = result;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check_output("drain", 82'(exp_q.size()), 82'd0);
    endtask

    always @(negedge clk) begin
        rec_t got;
        if (!rst && bus.exers_issue_valid && !bus.alu_stall && !bus.rob_flush) begin
            got.op    = bus.exers_issue_op;
            got.robid = bus.exers_issue_robid;
            got.rd    = bus.exers_issue_rd;
            got.op1   = bus.exers_issue_op1;
            got.op2   = bus.exers_issue_op2;
            if (exp_q.size() == 0) begin
                check_output("unexpected_issue", got, 82'd0);
            end else begin
                check_output("issue", got, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rename_exers_write = 1'b0;
        bus.rename_op = '0;
        bus.rename_robid = '0;
        bus.rename_rd = '0;
        bus.rename_op1ready = 1'b0;
        bus.rename_op2ready = 1'b0;
        bus.rename_op1 = '0;
        bus.rename_op2 = '0;
        bus.wb_valid = 1'b0;
        bus.wb_robid = '0;
        bus.wb_result = '0;
        bus.alu_stall = 1'b0;
        bus.rob_flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_stall", bus.exers_stall, 0);
        check_output("reset_issue_valid", bus.exers_issue_valid, 0);
        rst = 1'b0;
        tick();
        check_output("post_reset_stall", bus.exers_stall, 0);

        // Fill to full, hold a fifth write, then drain through wakeups.
        exp_q.push_back(mk(3, 3, 3, 32'h300, 32'h1003));
        exp_q.push_back(mk(7, 7, 6'h25, 32'h70, 32'h71));
        exp_q.push_back(mk(1, 1, 1, 32'h100, 32'h1001));
        exp_q.push_back(mk(2, 2, 2, 32'h200, 32'h1002));
        exp_q.push_back(mk(4, 4, 4, 32'h400, 32'h1004));
        for (int r = 1; r <= 4; r++) begin
            apply_stimulus(r, r, r, 1'b0, 32'(29 + r), 1'b1, 32'h1000 + 32'(r));
            tick();
            if (r == 3) check_output("fill_3_stall", bus.exers_stall, 0);
        end
        check_output("fill_4_stall", bus.exers_stall, 1);
        apply_stimulus(7, 7, 6'h25, 1'b1, 32'h70, 1'b1, 32'h71);
        repeat (2) tick();
        check_output("held_stall", bus.exers_stall, 1);
        check_output("held_no_issue", bus.exers_issue_valid, 0);
        broadcast(32, 32'h300);
        tick();
        bus.wb_valid = 1'b0;
        check_output("full_issue_stall", bus.exers_stall, 1);
        check_output("woken_issue_valid", bus.exers_issue_valid, 1);
        tick();
        check_output("after_issue_stall", bus.exers_stall, 0);
        tick();
        bus.rename_exers_write = 1'b0;
        tick();
        broadcast(30, 32'h100);
        tick();
        broadcast(31, 32'h200);
        tick();
        broadcast(33, 32'h400);
        tick();
        bus.wb_valid = 1'b0;
        wait_drain();

        // Younger entry woken first issues first.
        exp_q.push_back(mk(6, 6, 6, 32'h55, 32'h60));
        exp_q.push_back(mk(5, 5, 5, 32'hAA, 32'h50));
        apply_stimulus(5, 5, 5, 1'b0, 32'd20, 1'b1, 32'h50);
        tick();
        apply_stimulus(6, 6, 6, 1'b0, 32'd21, 1'b1, 32'h60);
        tick();
        bus.rename_exers_write = 1'b0;
        check_output("age_none_ready", bus.exers_issue_valid, 0);
        broadcast(21, 32'h55);
        tick();
        broadcast(20, 32'hAA);
        tick();
        bus.wb_valid = 1'b0;
        wait_drain();

        // Writeback in the allocate cycle, then both operands on one tag.
        exp_q.push_back(mk(8, 2, 8, 32'h1234, 32'h22));
        apply_stimulus(8, 2, 8, 1'b0, 32'd9, 1'b1, 32'h22);
        broadcast(9, 32'h1234);
        tick();
        bus.rename_exers_write = 1'b0;
        bus.wb_valid = 1'b0;
        check_output("bypass_valid", bus.exers_issue_valid, 1);
        check_output("bypass_op1", bus.exers_issue_op1, 32'h1234);
        wait_drain();
        exp_q.push_back(mk(10, 4, 10, 32'hBEEF, 32'hBEEF));
        apply_stimulus(10, 4, 10, 1'b0, 32'd11, 1'b0, 32'd11);
        tick();
        bus.rename_exers_write = 1'b0;
        check_output("dual_not_ready", bus.exers_issue_valid, 0);
        broadcast(11, 32'hBEEF);
        tick();
        bus.wb_valid = 1'b0;
        wait_drain();

        // ALU backpressure holds the issue slot steady.
        bus.alu_stall = 1'b1;
        exp_q.push_back(mk(12, 3, 6'h3F, 32'hC1, 32'hC2));
        apply_stimulus(12, 3, 6'h3F, 1'b1, 32'hC1, 1'b1, 32'hC2);
        tick();
        bus.rename_exers_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_output("bp_valid", bus.exers_issue_valid, 1);
            check_output("bp_robid", bus.exers_issue_robid, 12);
            check_output("bp_op2", bus.exers_issue_op2, 32'hC2);
            tick();
        end
        bus.alu_stall = 1'b0;
        tick();
        check_output("bp_removed", bus.exers_issue_valid, 0);
        wait_drain();

        // Flush with a simultaneous write empties the station.
        for (int r = 13; r <= 15; r++) begin
            apply_stimulus(r, 1, r, 1'b0, 32'(27 + r), 1'b1, 32'h5);
            tick();
        end
        apply_stimulus(16, 1, 16, 1'b1, 32'h1, 1'b1, 32'h2);
        bus.rob_flush = 1'b1;
        tick();
        bus.rob_flush = 1'b0;
        bus.rename_exers_write = 1'b0;
        check_output("flush_issue_valid", bus.exers_issue_valid, 0);
        broadcast(40, 32'h1);
        tick();
        bus.wb_valid = 1'b0;
        check_output("flush_no_wake", bus.exers_issue_valid, 0);
        for (int r = 17; r <= 20; r++) begin
            apply_stimulus(r, 1, r, 1'b0, 32'(33 + r), 1'b1, 32'h5);
            tick();
            if (r == 19) check_output("refill_3_stall", bus.exers_stall, 0);
        end
        bus.rename_exers_write = 1'b0;
        check_output("refill_full", bus.exers_stall, 1);

        // Mid-cycle reset while full.
        #1;
        rst = 1'b1;
        #1;
        check_output("rst_async_stall", bus.exers_stall, 0);
        check_output("rst_issue_valid", bus.exers_issue_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        check_output("post_rst_stall", bus.exers_stall, 0);
        broadcast(50, 32'h9);
        tick();
        bus.wb_valid = 1'b0;
        check_output("post_rst_no_issue", bus.exers_issue_valid, 0);
        tick();
        check_output("final_queue", 82'(exp_q.size()), 82'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
